bist_seq_ctrl: RTL and testbench

//  Built-in self-test sequencer for the 10-in/15-out combinational benchmark cores.
//  - Drives pseudo-random patterns from a 10-bit LFSR into the core under test (CUT).
//  - Compacts the 15-bit CUT response each cycle into a 16-bit MISR signature.
//  - Sits beside the CUT and is controlled by a start/abort/done handshake from the test host.

---
 rtl/bist_seq_ctrl_if.sv | 27 ++
 rtl/bist_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_bist_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bist_seq_ctrl_if.sv
// Host/CUT-side bundle of the BIST sequencer; golden/pass exist only with SIG_COMPARE_EN.
// Latency: none (wires only). Backpressure: none, start/abort are level-sampled by the sequencer.
`timescale 1ns/1ps
interface bist_seq_ctrl_if;
    logic        start;
    logic        abort;
    logic [9:0]  cut_pi;
    logic [14:0] cut_po;
    logic        busy;
    logic        done;
    logic [9:0]  pat_cnt;
    logic [15:0] signature;
`ifdef SIG_COMPARE_EN
    logic [15:0] golden;
    logic        pass;

    modport slave  (input  start, abort, cut_po, golden,
                    output cut_pi, busy, done, pat_cnt, signature, pass);
    modport master (output start, abort, cut_po, golden,
                    input  cut_pi, busy, done, pat_cnt, signature, pass);
`else
    modport slave  (input  start, abort, cut_po,
                    output cut_pi, busy, done, pat_cnt, signature);
    modport master (output start, abort, cut_po,
                    input  cut_pi, busy, done, pat_cnt, signature);
`endif
endinterface

// File: rtl/bist_seq_ctrl.sv
// LFSR pattern generator + MISR compactor BIST sequencer; SIG_COMPARE_EN adds golden compare/pass.
// Latency: pattern driven at edge k, its response absorbed at edge k+1; one pattern per cycle.
// Backpressure: none; abort beats start, start is ignored while running.
`timescale 1ns/1ps
module bist_seq_ctrl #(
    parameter int unsigned N_PAT     = 1023,
    parameter logic [9:0]  SEED      = 10'h001,
    parameter logic [15:0] MISR_SEED = 16'h0000
) (
    input  logic           clk,
    input  logic           rst_n,
    bist_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  lfsr_q, lfsr_d;
    logic [9:0]  cut_pi_q, cut_pi_d;
    logic [15:0] misr_q, misr_d;
    logic [9:0]  pat_cnt_q, pat_cnt_d;

    logic [9:0]  lfsr_nxt;
    logic [15:0] misr_shift;
    logic [15:0] misr_nxt;
    logic        last_pat;

    // x^10+x^7+1 Fibonacci LFSR, and CRC-16 (0x1021) style MISR
    assign lfsr_nxt   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    assign misr_shift = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000);
    assign misr_nxt   = misr_shift ^ {1'b0, bus.cut_po};
    assign last_pat   = (pat_cnt_q == 10'(N_PAT - 1));

`ifdef SIG_COMPARE_EN
    logic pass_q, pass_d;
    assign bus.pass = pass_q;
`endif

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cut_pi_d  = cut_pi_q;
        misr_d    = misr_q;
        pat_cnt_d = pat_cnt_q;
`ifdef SIG_COMPARE_EN
        pass_d    = pass_q;
`endif
        if (bus.abort) begin
            // signature and pat_cnt are deliberately left frozen for host inspection
            state_d  = IDLE;
            cut_pi_d = '0;
`ifdef SIG_COMPARE_EN
            pass_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d   = RUN;
                        lfsr_d    = SEED;
                        cut_pi_d  = SEED;
                        misr_d    = MISR_SEED;
                        pat_cnt_d = '0;
`ifdef SIG_COMPARE_EN
                        pass_d    = 1'b0;
`endif
                    end
                end
                RUN: begin
                    misr_d    = misr_nxt;
                    pat_cnt_d = pat_cnt_q + 10'd1;
                    lfsr_d    = lfsr_nxt;
                    if (last_pat) begin
                        state_d  = DONE;
                        cut_pi_d = '0;
`ifdef SIG_COMPARE_EN
                        pass_d   = (misr_nxt == bus.golden);
`endif
                    end else begin
                        cut_pi_d = lfsr_nxt;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    cut_pi_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            cut_pi_q  <= '0;
            misr_q    <= '0;
            pat_cnt_q <= '0;
`ifdef SIG_COMPARE_EN
            pass_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cut_pi_q  <= cut_pi_d;
            misr_q    <= misr_d;
            pat_cnt_q <= pat_cnt_d;
`ifdef SIG_COMPARE_EN
            pass_q    <= pass_d;
`endif
        end
    end

    assign bus.cut_pi    = cut_pi_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.pat_cnt   = pat_cnt_q;
    assign bus.signature = misr_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Directed bench for bist_seq_ctrl: three instances (8-, 1- and 1023-pattern runs).
`timescale 1ns/1ps
module tb_bist_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bist_seq_ctrl_if if8 ();
    bist_seq_ctrl_if if1 ();
    bist_seq_ctrl_if ifF ();

    assign if8.cut_po = {if8.cut_pi[4:0], if8.cut_pi};
    assign if1.cut_po = 15'h0001;
    assign ifF.cut_po = {5'd0, ifF.cut_pi};

    bist_seq_ctrl #(.N_PAT(8),    .SEED(10'h001), .MISR_SEED(16'h0000)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    bist_seq_ctrl #(.N_PAT(1),    .SEED(10'h001), .MISR_SEED(16'h0000)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    bist_seq_ctrl #(.N_PAT(1023), .SEED(10'h001), .MISR_SEED(16'h0000)) dutF (.clk(clk), .rst_n(rst_n), .bus(ifF.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference signature for the if8 CUT (response = {p[4:0], p}) after n patterns
    function automatic logic [15:0] sig_ref(input int n);
        logic [9:0]  p;
        logic [15:0] m;
        logic [14:0] r;
        p = 10'h001;
        m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            r = {p[4:0], p};
            m = (m << 1) ^ (m[15] ? 16'h1021 : 16'h0000) ^ {1'b0, r};
            p = {p[8:0], p[9] ^ p[6]};
        end
        return m;
    endfunction

    logic [9:0]    pat_tab [8];
    logic [1023:0] seen;
    int            uniq;
    int            bad;

    initial begin
        pat_tab = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h081};
        if8.start = 0; if8.abort = 0;
        if1.start = 0; if1.abort = 0;
        ifF.start = 0; ifF.abort = 0;
`ifdef SIG_COMPARE_EN
        if8.golden = '0;
        if1.golden = 16'h0001;
        ifF.golden = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(if8.busy),      32'd0);
        chk("rst_done",   32'(if8.done),      32'd0);
        chk("rst_patcnt", 32'(if8.pat_cnt),   32'd0);
        chk("rst_sig",    32'(if8.signature), 32'd0);
        chk("rst_cutpi",  32'(if8.cut_pi),    32'd0);
        rst_n = 1'b1;

        // 8-pattern run, start pulsed for one cycle
        @(negedge clk); if8.start = 1;
        @(negedge clk); if8.start = 0;
        for (int k = 0; k < 8; k++) begin
            chk("run8_cutpi",  32'(if8.cut_pi),  32'(pat_tab[k]));
            chk("run8_busy",   32'(if8.busy),    32'd1);
            chk("run8_patcnt", 32'(if8.pat_cnt), 32'(k));
            @(negedge clk);
        end
        chk("run8_done",   32'(if8.done),      32'd1);
        chk("run8_busy0",  32'(if8.busy),      32'd0);
        chk("run8_patcnt", 32'(if8.pat_cnt),   32'd8);
        chk("run8_cutpi0", 32'(if8.cut_pi),    32'd0);
        chk("run8_sig",    32'(if8.signature), 32'(sig_ref(8)));

        // start held high for the whole run must not restart it
        if8.start = 1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("hold_done",   32'(if8.done),      32'd1);
        chk("hold_patcnt", 32'(if8.pat_cnt),   32'd8);
        chk("hold_sig",    32'(if8.signature), 32'(sig_ref(8)));
        if8.start = 0;

        // abort at pat_cnt == 5, then restart
        @(negedge clk); if8.start = 1;
        @(negedge clk); if8.start = 0;
        repeat (5) @(negedge clk);
        chk("abt_pre_patcnt", 32'(if8.pat_cnt), 32'd5);
        if8.abort = 1;
        @(negedge clk); if8.abort = 0;
        chk("abt_busy",   32'(if8.busy),      32'd0);
        chk("abt_done",   32'(if8.done),      32'd0);
        chk("abt_patcnt", 32'(if8.pat_cnt),   32'd5);
        chk("abt_cutpi",  32'(if8.cut_pi),    32'd0);
        chk("abt_sig",    32'(if8.signature), 32'(sig_ref(5)));
        @(negedge clk);
        chk("abt_hold_patcnt", 32'(if8.pat_cnt),   32'd5);
        chk("abt_hold_sig",    32'(if8.signature), 32'(sig_ref(5)));
        if8.start = 1;
        @(negedge clk); if8.start = 0;
        chk("rest_cutpi",  32'(if8.cut_pi),  32'h001);
        chk("rest_patcnt", 32'(if8.pat_cnt), 32'd0);
        chk("rest_busy",   32'(if8.busy),    32'd1);
        repeat (8) @(negedge clk);
        chk("rest_done", 32'(if8.done),      32'd1);
        chk("rest_sig",  32'(if8.signature), 32'(sig_ref(8)));

        // start & abort together: abort wins, from DONE and from IDLE
        if8.start = 1; if8.abort = 1;
        @(negedge clk);
        chk("sa_done_busy", 32'(if8.busy), 32'd0);
        chk("sa_done_done", 32'(if8.done), 32'd0);
        @(negedge clk);
        chk("sa_idle_busy",  32'(if8.busy),   32'd0);
        chk("sa_idle_cutpi", 32'(if8.cut_pi), 32'd0);
        if8.start = 0; if8.abort = 0;

        // asynchronous reset in the middle of a run
        @(negedge clk); if8.start = 1;
        @(negedge clk); if8.start = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy",   32'(if8.busy),      32'd0);
        chk("mrst_patcnt", 32'(if8.pat_cnt),   32'd0);
        chk("mrst_sig",    32'(if8.signature), 32'd0);
        chk("mrst_cutpi",  32'(if8.cut_pi),    32'd0);
        @(negedge clk); rst_n = 1'b1;

        // single-pattern run with response tied to 1
        @(negedge clk); if1.start = 1;
        @(negedge clk); if1.start = 0;
        chk("one_busy",  32'(if1.busy),   32'd1);
        chk("one_cutpi", 32'(if1.cut_pi), 32'h001);
        @(negedge clk);
        chk("one_sig",    32'(if1.signature), 32'h0001);
        chk("one_done",   32'(if1.done),      32'd1);
        chk("one_patcnt", 32'(if1.pat_cnt),   32'd1);
`ifdef SIG_COMPARE_EN
        chk("one_pass", 32'(if1.pass), 32'd1);
        if1.golden = 16'h0002;
        if1.start = 1;
        @(negedge clk); if1.start = 0;
        chk("one_pass_clr", 32'(if1.pass), 32'd0);
        @(negedge clk);
        chk("one_sig2",  32'(if1.signature), 32'h0001);
        chk("one_pass2", 32'(if1.pass),      32'd0);
`endif

        // full 1023-pattern run: every nonzero value exactly once
        seen = '0; uniq = 0; bad = 0;
        @(negedge clk); ifF.start = 1;
        @(negedge clk); ifF.start = 0;
        for (int c = 0; c < 1100 && !ifF.done; c++) begin
            if (ifF.busy) begin
                if (ifF.cut_pi == 10'd0 || seen[ifF.cut_pi]) bad++;
                else begin
                    seen[ifF.cut_pi] = 1'b1;
                    uniq++;
                end
            end
            @(negedge clk);
        end
        chk("full_done",   32'(ifF.done),    32'd1);
        chk("full_uniq",   32'(uniq),        32'd1023);
        chk("full_bad",    32'(bad),         32'd0);
        chk("full_patcnt", 32'(ifF.pat_cnt), 32'd1023);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
